maze_route_reader: RTL and testbench

Downstream stage of the maze router. It starts when the router raises `D`, then scans the whole 256-cell SRAM map. Each routed cell is streamed out over a valid/ready interface, tagged with its net: 0x00 marks net 1 and 0x11 marks net 2. It also produces per-net cell counts. It shares the SRAM port with the router, and owns the port only while `busy` is high.

---
 rtl/maze_route_reader_if.sv | 29 ++
 rtl/maze_route_reader.sv | 192 +++++++++++++++++++
 tb/tb_maze_route_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_route_reader_if.sv
// maze_route_reader_if
// Bundles the shared SRAM port and the routed-cell stream of the maze route
// reader. The reader is the master of both: it drives the SRAM address and
// control, and it sources the valid/ready cell stream.

interface maze_route_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  cs;
   logic                  we;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_out;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_cell;
   logic                  out_net;

   modport master (
      output cs, we, address, data_out, out_valid, out_cell, out_net,
      input  data_in, out_ready
   );

   modport slave (
      input  cs, we, address, data_out, out_valid, out_cell, out_net,
      output data_in, out_ready
   );
endinterface

// File: rtl/maze_route_reader.sv
// maze_route_reader
// Downstream stage of the maze router. After the router signals completion it
// walks all map cells in address order, streams every cell tagged as net 1 or
// net 2 out over valid/ready, and counts the cells of each net.
// Optional feature macro: MAZE_ROUTE_READER_CLEAR_EN -- when defined, every
// emitted cell is written back as FREE_CODE so the map is ready for reuse.
// Without it the block never writes the SRAM.

module maze_route_reader #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] NET1_CODE  = 8'h00,
   parameter logic [DATA_WIDTH-1:0] NET2_CODE  = 8'h11,
   parameter logic [DATA_WIDTH-1:0] FREE_CODE  = 8'hEE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   maze_route_reader_if.master bus,
   output logic                busy,
   output logic                done,
   output logic [8:0]          count1,
   output logic [8:0]          count2
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WT,
      SMP,
      EMIT,
`ifdef MAZE_ROUTE_READER_CLEAR_EN
      WB,
`endif
      FIN
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] address_q;
   logic [ADDR_WIDTH-1:0] cell_q;
   logic                  net_q;
   logic [8:0]            cnt1_q;
   logic [8:0]            cnt2_q;
   logic                  load_start;
   logic                  step_addr;
   logic                  take1;
   logic                  take2;
   logic                  last_cell;
   logic                  cs_c;
   logic                  we_c;
   logic                  valid_c;
   logic                  busy_c;
   logic                  done_c;

   // The scan ends on the last cell rather than wrapping the address.
   assign last_cell = &address_q;

   // State register; reset forces the SRAM port and stream idle at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus the per-state SRAM, stream and status strobes.
   always_comb begin
      next_state = state;
      load_start = 1'b0;
      step_addr  = 1'b0;
      take1      = 1'b0;
      take2      = 1'b0;
      cs_c       = 1'b0;
      we_c       = 1'b0;
      valid_c    = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_start = 1'b1;
               next_state = RD;
            end
         end
         RD: begin
            cs_c       = 1'b1;
            busy_c     = 1'b1;
            next_state = WT;
         end
         WT: begin
            cs_c       = 1'b1;
            busy_c     = 1'b1;
            next_state = SMP;
         end
         SMP: begin
            busy_c = 1'b1;
            if (bus.data_in == NET1_CODE) begin
               take1      = 1'b1;
               next_state = EMIT;
            end else if (bus.data_in == NET2_CODE) begin
               take2      = 1'b1;
               next_state = EMIT;
            end else if (last_cell) begin
               next_state = FIN;
            end else begin
               step_addr  = 1'b1;
               next_state = RD;
            end
         end
         EMIT: begin
            busy_c  = 1'b1;
            valid_c = 1'b1;
            if (bus.out_ready) begin
`ifdef MAZE_ROUTE_READER_CLEAR_EN
               next_state = WB;
`else
               if (last_cell) begin
                  next_state = FIN;
               end else begin
                  step_addr  = 1'b1;
                  next_state = RD;
               end
`endif
            end
         end
`ifdef MAZE_ROUTE_READER_CLEAR_EN
         WB: begin
            busy_c = 1'b1;
            cs_c   = 1'b1;
            we_c   = 1'b1;
            if (last_cell) begin
               next_state = FIN;
            end else begin
               step_addr  = 1'b1;
               next_state = RD;
            end
         end
`endif
         FIN: begin
            done_c     = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Address walk, latched stream payload and per-net counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address_q <= '0;
         cell_q    <= '0;
         net_q     <= 1'b0;
         cnt1_q    <= '0;
         cnt2_q    <= '0;
      end else begin
         if (load_start) begin
            address_q <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
         end else if (step_addr) begin
            address_q <= address_q + 1'b1;
         end
         if (take1 || take2) begin
            cell_q <= address_q;
            net_q  <= take2;
         end
         if (take1) begin
            cnt1_q <= cnt1_q + 9'd1;
         end
         if (take2) begin
            cnt2_q <= cnt2_q + 9'd1;
         end
      end
   end

   assign bus.cs        = cs_c;
   assign bus.we        = we_c;
   assign bus.address   = address_q;
   assign bus.data_out  = FREE_CODE & {DATA_WIDTH{we_c}};
   assign bus.out_valid = valid_c;
   assign bus.out_cell  = cell_q;
   assign bus.out_net   = net_q;
   assign busy          = busy_c;
   assign done          = done_c;
   assign count1        = cnt1_q;
   assign count2        = cnt2_q;

endmodule

// File: tb/tb_maze_route_reader.sv
// tb_maze_route_reader
// Directed bench for maze_route_reader. A behavioural SRAM with two-cycle read
// latency backs the DUT; expected stream cells are queued as each scan is set
// up and a monitor pops and compares them on every handshake. Scan lengths and
// counts are hand-computed. Builds with or without MAZE_ROUTE_READER_CLEAR_EN.

module tb_maze_route_reader;

`ifdef MAZE_ROUTE_READER_CLEAR_EN
   localparam int WB_CYC = 1;
`else
   localparam int WB_CYC = 0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [8:0] count1;
   logic [8:0] count2;

   maze_route_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   maze_route_reader dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .bus    (bus.master),
      .busy   (busy),
      .done   (done),
      .count1 (count1),
      .count2 (count2)
   );

   logic [7:0] mem [256];
   logic [7:0] rd_stage;
   logic [8:0] exp_q [$];
   int         check_count;
   int         pass_count;
   int         valid_cycles;
   int         stall_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: address captured on one edge, data presented after the next.
   always @(posedge clk) begin
      if (bus.cs && bus.we) begin
         mem[bus.address] <= bus.data_out;
      end
      if (bus.cs && !bus.we) begin
         rd_stage <= mem[bus.address];
      end
      bus.data_in <= rd_stage;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end else begin
         pass_count++;
      end
   endtask

   // Monitor: every accepted cell must match the head of the expected queue.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         valid_cycles++;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_cell", {23'd0, bus.out_cell, bus.out_net}, 32'h1ff);
         end else begin
            checkOutput("stream_cell_net", {23'd0, bus.out_cell, bus.out_net},
                        {23'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic loadMap(input int c0, input int c1, input int c2, input int c3,
                          input logic [7:0] v3);
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'hEE;
      end
      mem[7] = 8'hFF;
      mem[100] = 8'h42;
      if (c0 >= 0) mem[c0] = 8'h00;
      if (c1 >= 0) mem[c1] = 8'h00;
      if (c2 >= 0) mem[c2] = 8'h00;
      if (c3 >= 0) mem[c3] = v3;
   endtask

   // Pulse start, then count cycles after the accepting edge until done.
   // A second one-cycle start pulse is injected at cycle extra_at when >= 0.
   task automatic applyStimulus(input int extra_at, output int cycles);
      logic found;
      found  = 1'b0;
      cycles = -1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 3000 && !found; cyc++) begin
         @(negedge clk);
         start = (cyc == extra_at);
         if (done) begin
            found  = 1'b1;
            cycles = cyc;
         end
      end
      start = 1'b0;
      checkOutput("scan_done_seen", {31'd0, found}, 32'd1);
   endtask

   task automatic stallProcess();
      int wait_cyc;
      wait_cyc = 0;
      stall_seen = 0;
      while (!bus.out_valid && wait_cyc < 3000) begin
         @(negedge clk);
         wait_cyc++;
      end
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid && bus.out_cell == 8'd255 && !bus.out_ready) begin
            stall_seen++;
         end
         if (i < 9) @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
   endtask

   initial begin
      int cycles;
      int wait_cyc;
      int v0;
      check_count  = 0;
      pass_count   = 0;
      valid_cycles = 0;
      stall_seen   = 0;
      rd_stage     = 8'h00;
      reset        = 1'b0;
      start        = 1'b0;
      bus.out_ready = 1'b1;
      loadMap(-1, -1, -1, -1, 8'hEE);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_cs_we", {30'd0, bus.cs, bus.we}, 32'd0);
      checkOutput("rst_address", {24'd0, bus.address}, 32'd0);
      checkOutput("rst_data_out", {24'd0, bus.data_out}, 32'd0);
      checkOutput("rst_stream", {22'd0, bus.out_valid, bus.out_cell, bus.out_net}, 32'd0);
      checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
      checkOutput("rst_counts", {14'd0, count1, count2}, 32'd0);
      reset = 1'b1;

      // Empty map: 256 cells x 3 cycles, done in the following cycle
      v0 = valid_cycles;
      applyStimulus(-1, cycles);
      checkOutput("empty_done_cycle", cycles, 769);
      checkOutput("empty_counts", {14'd0, count1, count2}, 32'd0);
      checkOutput("empty_busy_at_fin", {31'd0, busy}, 32'd0);
      @(negedge clk);
      checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
      checkOutput("empty_no_valid", valid_cycles - v0, 0);

      // Three net-1 cells and one net-2 cell, consumer always ready
      loadMap(5, 13, 21, 200, 8'h11);
      exp_q.push_back({8'd5, 1'b0});
      exp_q.push_back({8'd13, 1'b0});
      exp_q.push_back({8'd21, 1'b0});
      exp_q.push_back({8'd200, 1'b1});
      applyStimulus(-1, cycles);
      checkOutput("map2_done_cycle", cycles, 769 + 4 * (1 + WB_CYC));
      checkOutput("map2_count1", {23'd0, count1}, 32'd3);
      checkOutput("map2_count2", {23'd0, count2}, 32'd1);
      checkOutput("map2_queue_drained", exp_q.size(), 0);
`ifdef MAZE_ROUTE_READER_CLEAR_EN
      checkOutput("clear_mem", {mem[5], mem[13], mem[21], mem[200]}, 32'hEEEEEEEE);
      checkOutput("clear_obstacle_kept", {24'd0, mem[7]}, 32'hFF);
      applyStimulus(-1, cycles);
      checkOutput("rescan_done_cycle", cycles, 769);
      checkOutput("rescan_counts", {14'd0, count1, count2}, 32'd0);
`else
      checkOutput("readonly_mem", {mem[5], mem[13], mem[21], mem[200]}, 32'h00000011);
`endif

      // Backpressure on the last cell
      loadMap(-1, -1, -1, 255, 8'h11);
      bus.out_ready = 1'b0;
      exp_q.push_back({8'd255, 1'b1});
      fork
         applyStimulus(-1, cycles);
         stallProcess();
      join
      checkOutput("stall_cycles", stall_seen, 10);
      checkOutput("last_done_cycle", cycles, 780 + WB_CYC);
      checkOutput("last_address", {24'd0, bus.address}, 32'd255);
      checkOutput("last_count2", {23'd0, count2}, 32'd1);

      // Asynchronous reset while a cell at 64 is waiting in EMIT
      loadMap(64, -1, -1, -1, 8'hEE);
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_cyc = 0;
      while (!(bus.out_valid && bus.out_cell == 8'd64) && wait_cyc < 3000) begin
         @(negedge clk);
         wait_cyc++;
      end
      checkOutput("emit64_reached", {31'd0, bus.out_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_valid_busy_cs", {29'd0, bus.out_valid, busy, bus.cs}, 32'd0);
      checkOutput("async_rst_address", {24'd0, bus.address}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      bus.out_ready = 1'b1;
      exp_q.push_back({8'd64, 1'b0});
      applyStimulus(-1, cycles);
      checkOutput("post_rst_done_cycle", cycles, 770 + WB_CYC);
      checkOutput("post_rst_counts", {14'd0, count1, count2}, {14'd0, 9'd1, 9'd0});

      // Extra start pulse mid-scan is ignored
      loadMap(5, 13, 21, 200, 8'h11);
      exp_q.push_back({8'd5, 1'b0});
      exp_q.push_back({8'd13, 1'b0});
      exp_q.push_back({8'd21, 1'b0});
      exp_q.push_back({8'd200, 1'b1});
      applyStimulus(100, cycles);
      checkOutput("restart_done_cycle", cycles, 769 + 4 * (1 + WB_CYC));
      checkOutput("restart_counts", {14'd0, count1, count2}, {14'd0, 9'd3, 9'd1});
      repeat (3) @(negedge clk);
      checkOutput("restart_idle_after", {31'd0, busy}, 32'd0);
      checkOutput("final_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
